// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: memory req/ack side, EX redirect and ID handshake.
// master is the fetch stage, slave is memory/EX/ID around it.
interface if_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [INST_W-1:0] mem_data_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_pc_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              if_stall_o;

    modport master (
        output mem_req_o, mem_addr_o,
        input  mem_ack_i, mem_data_i,
        input  jump_i, jump_pc_i,
        output id_valid_o,
        input  id_ready_i,
        output pc_o, inst_o, if_stall_o
    );

    modport slave (
        input  mem_req_o, mem_addr_o,
        output mem_ack_i, mem_data_i,
        output jump_i, jump_pc_i,
        input  id_valid_o,
        output id_ready_i,
        input  pc_o, inst_o, if_stall_o
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: sequential req/ack fetcher feeding a
// DEPTH-entry prefetch FIFO towards ID, flushed on jump.
module if_fetch_queue #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    if_fetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt_pop;
    logic [CW-1:0]     cnt_push;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              jump;
    logic              pop;
    logic              push;

    assign jump     = bus.jump_i;
    assign pop      = (count != '0) & bus.id_ready_i & ~jump;
    assign push     = (state == REQ) & bus.mem_ack_i & ~jump;
    assign cnt_pop  = count - CW'(pop);
    assign cnt_push = count + CW'(1) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A request is only raised with a free slot, so the FIFO never overflows.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!jump && cnt_pop < CW'(DEPTH))
                    state_nxt = REQ;
            end
            REQ: begin
                if (bus.mem_ack_i)
                    state_nxt = (!jump && cnt_push < CW'(DEPTH)) ? REQ : IDLE;
                else if (jump)
                    state_nxt = DROP;
            end
            DROP: begin
                if (bus.mem_ack_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req_o  = (state != IDLE);
        bus.mem_addr_o = req_addr;
        bus.id_valid_o = (count != '0);
        bus.if_stall_o = (count == '0);
        bus.pc_o       = pc_mem[rd_ptr];
        bus.inst_o     = inst_mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_addr <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            if (state == IDLE && state_nxt == REQ)
                req_addr <= fetch_pc;
            else if (push && state_nxt == REQ)
                req_addr <= req_addr + ADDR_W'(4);

            // Jump flushes and wins over any push or pop this cycle.
            if (jump) begin
                fetch_pc <= bus.jump_pc_i;
                count    <= '0;
                rd_ptr   <= wr_ptr;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]   <= req_addr;
                    inst_mem[wr_ptr] <= bus.mem_data_i;
                    wr_ptr           <= wr_ptr + PW'(1);
                    fetch_pc         <= req_addr + ADDR_W'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Random-stimulus scoreboard bench for if_fetch_queue against a
// stream-level model of the fetch address sequence and queue contents.
module tb_if_fetch_queue;
    localparam int          AW    = 32;
    localparam int          IW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0040;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

    if_fetch_queue #(
        .ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   failures = 0;
    ent_t sb[$];

    // model of the fetch stream
    int          mcnt;
    logic [31:0] exp_addr;
    logic [31:0] raddr;
    bit          outst;
    bit          tainted;
    bit          exp_req;
    bit          post_rst;

    // stimulus knobs
    bit          rst_req = 1'b1;
    int          rdy_pct = 100;
    int          jmp_div = 0;
    int          lat_max = 0;
    int          stray_pct = 0;
    bit          force_jmp = 1'b0;
    logic [31:0] force_tgt = '0;
    bit          busy = 1'b0;
    int          wcnt = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    task automatic drive();
        logic [31:0] tgt;
        rst = rst_req;
        bus.id_ready_i = ($urandom_range(0, 99) < rdy_pct);
        bus.jump_i = (jmp_div != 0) &&
                     ($urandom_range(0, jmp_div - 1) == 0);
        case ($urandom_range(0, 3))
            0:       tgt = $urandom & 32'hFFFF_FFFC;
            1:       tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
            2:       tgt = $urandom;
            default: tgt = $urandom_range(0, 255) << 2;
        endcase
        bus.jump_pc_i = tgt;
        if (force_jmp) begin
            bus.jump_i    = 1'b1;
            bus.jump_pc_i = force_tgt;
            force_jmp     = 1'b0;
        end
        if (bus.mem_req_o) begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = $urandom_range(0, lat_max);
            end
            if (wcnt == 0) begin
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = mem_fn(bus.mem_addr_o);
                busy = 1'b0;
            end else begin
                bus.mem_ack_i  = 1'b0;
                bus.mem_data_i = $urandom;
                wcnt--;
            end
        end else begin
            busy = 1'b0;
            bus.mem_ack_i  = ($urandom_range(0, 99) < stray_pct);
            bus.mem_data_i = $urandom;
        end
    endtask

    task automatic bookkeep();
        bit pop;
        bit push;
        bit req;
        bit ack;
        bit jmp;
        if (rst) begin
            sb.delete();
            mcnt     = 0;
            exp_addr = RPC;
            outst    = 1'b0;
            tainted  = 1'b0;
            exp_req  = 1'b0;
            post_rst = 1'b1;
            return;
        end
        if (post_rst) begin
            chk("rst_mem_addr", bus.mem_addr_o, 0);
            chk("rst_id_valid", bus.id_valid_o, 0);
            chk("rst_stall", bus.if_stall_o, 1);
            chk("rst_pc", bus.pc_o, 0);
            chk("rst_inst", bus.inst_o, 0);
            post_rst = 1'b0;
        end
        req = bus.mem_req_o;
        ack = bus.mem_ack_i;
        jmp = bus.jump_i;
        chk("mem_req", req, exp_req);
        pop  = (mcnt != 0) && bus.id_ready_i && !jmp;
        push = 1'b0;
        if (req) begin
            if (!outst) begin
                chk("req_addr", bus.mem_addr_o, exp_addr);
                outst   = 1'b1;
                raddr   = bus.mem_addr_o;
                tainted = 1'b0;
            end else begin
                chk("addr_stable", bus.mem_addr_o, raddr);
            end
        end
        if (req && ack) begin
            outst = 1'b0;
            if (!jmp && !tainted) begin
                push = 1'b1;
                sb.push_back('{raddr, mem_fn(raddr)});
                exp_addr = raddr + 32'd4;
            end
        end
        // Is a request expected on the bus next cycle?
        if (!req)
            exp_req = !jmp && (mcnt - int'(pop) < DEPTH);
        else if (ack)
            exp_req = !jmp && !tainted &&
                      (mcnt + 1 - int'(pop) < DEPTH);
        else
            exp_req = 1'b1;
        if (jmp) begin
            exp_addr = bus.jump_pc_i;
            if (outst) tainted = 1'b1;
            sb.delete();
            mcnt = 0;
        end else begin
            mcnt = mcnt + int'(push) - int'(pop);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1 drive();
        @(negedge clk);
        #1 bookkeep();
    endtask

    // Monitor: compare the presented head against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("stall", bus.if_stall_o, !bus.id_valid_o);
                chk("valid", bus.id_valid_o, sb.size() != 0);
                if (bus.id_valid_o && sb.size() != 0) begin
                    chk("pc", bus.pc_o, sb[0].pc);
                    chk("inst", bus.inst_o, sb[0].inst);
                    if (bus.id_ready_i && !bus.jump_i)
                        void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bit reached;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        bus.jump_i     = 1'b0;
        bus.jump_pc_i  = '0;
        bus.id_ready_i = 1'b0;

        repeat (3) cycle();
        rst_req = 1'b0;
        repeat (30) cycle();

        rdy_pct = 0;
        lat_max = 1;
        repeat (20) cycle();
        chk("full_count", mcnt, DEPTH);
        chk("full_no_req", bus.mem_req_o, 0);
        rdy_pct = 100;
        repeat (15) cycle();

        rdy_pct   = 60;
        lat_max   = 3;
        jmp_div   = 12;
        stray_pct = 25;
        repeat (1500) cycle();

        jmp_div   = 0;
        stray_pct = 0;
        rdy_pct   = 0;
        reached   = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            cycle();
            reached = (mcnt >= 2) && bus.mem_req_o;
        end
        chk("fill_timeout", reached, 1);
        rst_req = 1'b1;
        cycle();
        rst_req   = 1'b0;
        stray_pct = 100;
        cycle();
        stray_pct = 0;
        rdy_pct   = 100;
        lat_max   = 0;
        repeat (20) cycle();

        force_tgt = 32'hFFFF_FFF8;
        force_jmp = 1'b1;
        repeat (12) cycle();

        rdy_pct   = 70;
        lat_max   = 2;
        jmp_div   = 20;
        stray_pct = 10;
        repeat (600) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
